mem_store_buffer: RTL and testbench

MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

---
 rtl/mem_store_buffer.sv | 80 ++++++++
 tb/tb_mem_store_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// Store buffer between the CPU memory stage and the data RAM / peripheral bus.
// RAM stores pass straight through; peripheral-region stores queue in a FIFO.
module mem_store_buffer #(
    parameter int unsigned DEPTH       = 4,
    parameter logic [3:0]  PERIPH_BASE = 4'hF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_enable,
    input  logic [31:0]                WriteAddress,
    input  logic [31:0]                WriteData,
    output logic                       ram_we,
    output logic [31:0]                ram_addr,
    output logic [31:0]                ram_wdata,
    output logic                       p_valid,
    output logic [31:0]                p_addr,
    output logic [31:0]                p_data,
    input  logic                       p_ready,
    output logic                       stall,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             periph_hit;
    logic             full;
    logic             push;
    logic             pop;

    // Address decode and RAM pass-through
    assign periph_hit = (WriteAddress[31:28] == PERIPH_BASE);
    assign ram_we     = write_enable && !periph_hit;
    assign ram_addr   = WriteAddress;
    assign ram_wdata  = WriteData;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign stall  = write_enable && periph_hit && full;
    assign push   = write_enable && periph_hit && !full;
    assign pop    = !empty && p_ready;

    // Head entry shown directly from storage
    assign p_valid = !empty;
    assign p_addr  = addr_mem[head];
    assign p_data  = data_mem[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_mem[tail] <= WriteAddress;
                data_mem[tail] <= WriteData;
                tail           <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            // Pointers wrap naturally since DEPTH is a power of two
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer with a small queue model of expected order.
module tb_mem_store_buffer;

    logic        clk;
    logic        reset;
    logic        write_enable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        p_valid;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    logic        p_ready;
    logic        stall;
    logic [2:0]  count;
    logic        empty;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    mem_store_buffer #(.DEPTH(4), .PERIPH_BASE(4'hF)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .p_valid      (p_valid),
        .p_addr       (p_addr),
        .p_data       (p_data),
        .p_ready      (p_ready),
        .stall        (stall),
        .count        (count),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check comb outputs against model, clock, update model
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy);
        logic hit;
        logic m_push;
        logic m_pop;
        write_enable = we;
        WriteAddress = a;
        WriteData    = d;
        p_ready      = rdy;
        #1;
        hit    = (a[31:28] == 4'hF);
        m_push = we && hit && (q.size() < 4);
        m_pop  = (q.size() != 0) && rdy;
        chk("count",   32'(count),   32'(q.size()));
        chk("empty",   32'(empty),   32'(q.size() == 0));
        chk("p_valid", 32'(p_valid), 32'(q.size() != 0));
        chk("stall",   32'(stall),   32'(we && hit && (q.size() == 4)));
        chk("ram_we",  32'(ram_we),  32'(we && !hit));
        if (q.size() != 0) begin
            chk("p_addr", p_addr, q[0].a);
            chk("p_data", p_data, q[0].d);
        end
        @(posedge clk);
        if (m_pop)  void'(q.pop_front());
        if (m_push) q.push_back({a, d});
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b0;
        write_enable = 1'b0;
        WriteAddress = '0;
        WriteData    = '0;
        p_ready      = 1'b0;
        #2;
        chk("rst_p_valid", 32'(p_valid), 32'd0);
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_empty",   32'(empty),   32'd1);
        chk("rst_p_addr",  p_addr,       32'd0);
        chk("rst_p_data",  p_data,       32'd0);
        @(negedge clk);
        reset = 1'b1;

        // RAM store passes through, FIFO untouched
        write_enable = 1'b1; WriteAddress = 32'h0000_0010; WriteData = 32'h0000_00A5;
        #1;
        chk("ram_addr",  ram_addr,  32'h0000_0010);
        chk("ram_wdata", ram_wdata, 32'h0000_00A5);
        step(1'b1, 32'h0000_0010, 32'h0000_00A5, 1'b0);
        chk("ram_store_count", 32'(count), 32'd0);

        // Single peripheral store, visible next cycle
        step(1'b1, 32'hF000_0004, 32'h0000_1234, 1'b0);
        #1;
        chk("first_p_valid", 32'(p_valid), 32'd1);
        chk("first_p_addr",  p_addr,       32'hF000_0004);
        chk("first_p_data",  p_data,       32'h0000_1234);

        // Fill to full, fifth store stalls
        step(1'b1, 32'hF000_0008, 32'h2, 1'b0);
        step(1'b1, 32'hF000_000C, 32'h3, 1'b0);
        step(1'b1, 32'hF000_0010, 32'h4, 1'b0);
        step(1'b1, 32'hF000_0014, 32'h5, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_stall", 32'(stall), 32'd1);
        step(1'b1, 32'hF000_0014, 32'h5, 1'b1);
        chk("after_pop_count", 32'(count), 32'd3);
        chk("after_pop_stall", 32'(stall), 32'd0);
        chk("after_pop_head",  p_addr,     32'hF000_0008);
        step(1'b1, 32'hF000_0014, 32'h5, 1'b0);
        chk("fifth_in_count", 32'(count), 32'd4);

        // Drain in order
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("drained_empty", 32'(empty), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0);

        // Two queued, then ten push+pop pairs across pointer wrap
        step(1'b1, 32'hF100_0000, 32'hA0, 1'b0);
        step(1'b1, 32'hF100_0004, 32'hA1, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'hF200_0000 + 32'(i * 4), 32'hB0 + 32'(i), 1'b1);
        chk("mixed_count", 32'(count), 32'd2);
        chk("mixed_head",  p_addr,     32'hF200_0020);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0);

        // Reset mid-drain
        step(1'b1, 32'hF000_0100, 32'hC0, 1'b0);
        step(1'b1, 32'hF000_0104, 32'hC1, 1'b0);
        step(1'b1, 32'hF000_0108, 32'hC2, 1'b0);
        write_enable = 1'b0;
        p_ready      = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_p_valid", 32'(p_valid), 32'd0);
        chk("midrst_count",   32'(count),   32'd0);
        chk("midrst_empty",   32'(empty),   32'd1);
        q.delete();
        @(posedge clk);
        #1;
        chk("midrst_hold_p_valid", 32'(p_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // p_ready held while empty, then late arrival
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 32'hF000_0200, 32'hD0, 1'b1);
        chk("late_count", 32'(count), 32'd1);
        chk("late_addr",  p_addr,     32'hF000_0200);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
